wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter_pkg.sv | 20 ++
 rtl/wb_arbiter_rr_picker.sv | 60 ++++++
 rtl/wb_arbiter.sv | 109 ++++++++++
 tb/tb_wb_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared writeback-arbiter definitions: port count, register address width
// and the entry layout held in each writeback output register.
package wb_arbiter_pkg;

    localparam int DISPATCH_WIDTH       = 2;
    localparam int WB_PORTS             = DISPATCH_WIDTH;
    localparam int PHYS_REGS_ADDR_WIDTH = 6;
    localparam int WB_DATA_WIDTH        = 32;

    typedef struct packed {
        logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
        logic [31:0]                     data;
    } wb_entry_t;

    // Saturating 32-bit increment for event counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// Rotating-priority picker: grants up to WB_PORTS valid requesters starting
// at rr_ptr, reports which requester lands on each port and the next pointer.
module wb_rr_picker
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_FU   = 4,
    parameter int WB_PORTS = 2,
    localparam int PTR_W   = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0]               valid_i,
    input  logic [PTR_W-1:0]                rr_ptr_i,
    output logic [NUM_FU-1:0]               grant_o,
    output logic [WB_PORTS-1:0][NUM_FU-1:0] sel_o,
    output logic [PTR_W-1:0]                next_ptr_o,
    output logic                            any_grant_o
);

    logic [2*NUM_FU-1:0]              dbl_valid;
    logic [NUM_FU-1:0]                rot_valid;
    logic [NUM_FU-1:0]                rot_grant;
    logic [WB_PORTS-1:0][NUM_FU-1:0]  rot_sel;
    logic [2*NUM_FU-1:0]              un_grant;

    // Work in a frame rotated so that position 0 is the current priority head.
    always_comb begin
        int cnt;
        int last_p;
        int nxt;
        dbl_valid  = {valid_i, valid_i} >> rr_ptr_i;
        rot_valid  = dbl_valid[NUM_FU-1:0];
        rot_grant  = '0;
        rot_sel    = '0;
        cnt        = 0;
        last_p     = 0;
        for (int p = 0; p < NUM_FU; p++) begin
            if (rot_valid[p] && cnt < WB_PORTS) begin
                rot_grant[p] = 1'b1;
                for (int k = 0; k < WB_PORTS; k++) begin
                    if (cnt == k) rot_sel[k][p] = 1'b1;
                end
                last_p = p;
                cnt    = cnt + 1;
            end
        end
        any_grant_o = (cnt != 0);
        nxt = last_p + 1 + int'(rr_ptr_i);
        if (nxt >= NUM_FU) nxt = nxt - NUM_FU;
        next_ptr_o = PTR_W'(nxt);
    end

    assign un_grant = {rot_grant, rot_grant} << rr_ptr_i;
    assign grant_o  = un_grant[2*NUM_FU-1:NUM_FU];

    for (genvar gi = 0; gi < WB_PORTS; gi++) begin : g_port
        logic [2*NUM_FU-1:0] un_sel;
        assign un_sel    = {rot_sel[gi], rot_sel[gi]} << rr_ptr_i;
        assign sel_o[gi] = un_sel[2*NUM_FU-1:NUM_FU];
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: up to WB_PORTS results per cycle, registered
// onto the writeback bus. WB_ARB_PERF_EN adds a saturating conflict counter.
module wb_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int WB_PORTS   = wb_arbiter_pkg::WB_PORTS,
    parameter int DATA_WIDTH = wb_arbiter_pkg::WB_DATA_WIDTH
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                flush,
    input  logic [NUM_FU-1:0]                                   req_valid,
    input  logic [NUM_FU*wb_arbiter_pkg::PHYS_REGS_ADDR_WIDTH-1:0]   req_phys_rd,
    input  logic [NUM_FU*DATA_WIDTH-1:0]                        req_data,
    output logic [NUM_FU-1:0]                                   req_ready,
    output logic [WB_PORTS-1:0]                                 wb_valid,
    output logic [WB_PORTS*wb_arbiter_pkg::PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd,
    output logic [WB_PORTS*DATA_WIDTH-1:0]                      wb_data
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]                                         perf_conflict_cnt
`endif
);
    import wb_arbiter_pkg::*;

    localparam int PTR_W = $clog2(NUM_FU);
    localparam int PRW   = PHYS_REGS_ADDR_WIDTH;

    wb_entry_t                       req_entry [NUM_FU];
    wb_entry_t                       wb_entry_q [WB_PORTS];
    wb_entry_t                       wb_entry_d [WB_PORTS];
    logic [WB_PORTS-1:0]             wb_valid_q, wb_valid_d;
    logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [NUM_FU-1:0]               pick_valid;
    logic [NUM_FU-1:0]               grant;
    logic [WB_PORTS-1:0][NUM_FU-1:0] sel;
    logic [PTR_W-1:0]                next_ptr;
    logic                            any_grant;

    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_req
        assign req_entry[gi].phys_rd = req_phys_rd[gi*PRW +: PRW];
        assign req_entry[gi].data    = WB_DATA_WIDTH'(req_data[gi*DATA_WIDTH +: DATA_WIDTH]);
    end

    // Reset and flush simply hide every request from the picker.
    assign pick_valid = req_valid & {NUM_FU{~(rst | flush)}};

    wb_rr_picker #(
        .NUM_FU   (NUM_FU),
        .WB_PORTS (WB_PORTS)
    ) u_picker (
        .valid_i     (pick_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant),
        .sel_o       (sel),
        .next_ptr_o  (next_ptr),
        .any_grant_o (any_grant)
    );

    assign req_ready = grant;

    always_comb begin
        rr_ptr_d = any_grant ? next_ptr : rr_ptr_q;
        for (int k = 0; k < WB_PORTS; k++) begin
            wb_valid_d[k] = |sel[k];
            wb_entry_d[k] = wb_entry_q[k];
            if (|sel[k]) begin
                wb_entry_d[k] = '0;
                for (int i = 0; i < NUM_FU; i++) begin
                    if (sel[k][i]) wb_entry_d[k] = wb_entry_d[k] | req_entry[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            wb_valid_q <= '0;
            for (int k = 0; k < WB_PORTS; k++) wb_entry_q[k] <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wb_valid_q <= wb_valid_d;
            for (int k = 0; k < WB_PORTS; k++) wb_entry_q[k] <= wb_entry_d[k];
        end
    end

    assign wb_valid = wb_valid_q;
    for (genvar gi = 0; gi < WB_PORTS; gi++) begin : g_wb
        assign wb_phys_rd[gi*PRW +: PRW]             = wb_entry_q[gi].phys_rd;
        assign wb_data[gi*DATA_WIDTH +: DATA_WIDTH]  = DATA_WIDTH'(wb_entry_q[gi].data);
    end

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (!flush && ($countones(req_valid) > WB_PORTS)) perf_cnt_d = sat_inc32(perf_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) perf_cnt_q <= '0;
        else     perf_cnt_q <= perf_cnt_d;
    end

    assign perf_conflict_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter (NUM_FU=4, WB_PORTS=2): directed cases
// with literal expectations, a fairness soak, then a randomized run.
module tb_wb_arbiter;
    localparam int NF  = 4;
    localparam int WBP = 2;
    localparam int PRW = wb_arbiter_pkg::PHYS_REGS_ADDR_WIDTH;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [NF-1:0]     req_valid;
    logic [NF*PRW-1:0] req_phys_rd;
    logic [NF*DW-1:0]  req_data;
    logic [NF-1:0]     req_ready;
    logic [WBP-1:0]    wb_valid;
    logic [WBP*PRW-1:0] wb_phys_rd;
    logic [WBP*DW-1:0] wb_data;
`ifdef WB_ARB_PERF_EN
    logic [31:0]       perf_conflict_cnt;
    logic [31:0]       m_perf;
`endif

    logic [PRW-1:0] rd_a  [NF];
    logic [DW-1:0]  dat_a [NF];

    int n_checks = 0;
    int n_fail   = 0;

    wb_arbiter #(.NUM_FU(NF), .WB_PORTS(WBP), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_phys_rd (req_phys_rd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wb_valid    (wb_valid),
        .wb_phys_rd  (wb_phys_rd),
        .wb_data     (wb_data)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NF; i++) begin
            req_phys_rd[i*PRW +: PRW] = rd_a[i];
            req_data[i*DW +: DW]      = dat_a[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rule: walk requesters in priority order from ptr, first WBP valid ones win.
    function automatic void pick(input logic [NF-1:0] v, input int ptr, input logic fl,
                                 input logic rs, output logic [NF-1:0] rdy,
                                 output int who [WBP], output int n);
        int order[$];
        rdy = '0;
        n   = 0;
        for (int k = 0; k < WBP; k++) who[k] = 0;
        if (fl || rs) return;
        for (int s = 0; s < NF; s++) order.push_back((ptr + s) % NF);
        foreach (order[j]) begin
            if (v[order[j]] && n < WBP) begin
                who[n] = order[j];
                rdy[order[j]] = 1'b1;
                n++;
            end
        end
    endfunction

    int             m_ptr;
    logic [WBP-1:0] m_wb_valid;
    logic [PRW-1:0] m_wb_rd  [WBP];
    logic [DW-1:0]  m_wb_dat [WBP];

    always @(posedge clk) begin
        logic [NF-1:0] r;
        int who [WBP];
        int n;
        pick(req_valid, m_ptr, flush, rst, r, who, n);
        if (rst) begin
            m_ptr      <= 0;
            m_wb_valid <= '0;
            for (int k = 0; k < WBP; k++) begin
                m_wb_rd[k]  <= '0;
                m_wb_dat[k] <= '0;
            end
        end else begin
            for (int k = 0; k < WBP; k++) begin
                if (k < n) begin
                    m_wb_valid[k] <= 1'b1;
                    m_wb_rd[k]    <= rd_a[who[k]];
                    m_wb_dat[k]   <= dat_a[who[k]];
                end else begin
                    m_wb_valid[k] <= 1'b0;
                end
            end
            if (n > 0) m_ptr <= (who[n-1] + 1) % NF;
        end
`ifdef WB_ARB_PERF_EN
        if (rst) m_perf <= '0;
        else if (!flush && $countones(req_valid) > WBP && m_perf != 32'hFFFF_FFFF) m_perf <= m_perf + 1;
`endif
    end

    // Per-cycle comparison plus requester-contract monitor.
    logic [NF-1:0]  hold_mask = '0;
    logic [PRW-1:0] hold_rd  [NF];
    logic [DW-1:0]  hold_dat [NF];

    always @(negedge clk) begin
        logic [NF-1:0] er;
        int who [WBP];
        int n;
        pick(req_valid, m_ptr, flush, rst, er, who, n);
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("wb_valid", 64'(wb_valid), 64'(m_wb_valid));
        for (int k = 0; k < WBP; k++) begin
            chk($sformatf("wb_phys_rd[%0d]", k), 64'(wb_phys_rd[k*PRW +: PRW]), 64'(m_wb_rd[k]));
            chk($sformatf("wb_data[%0d]", k), 64'(wb_data[k*DW +: DW]), 64'(m_wb_dat[k]));
        end
`ifdef WB_ARB_PERF_EN
        chk("perf_conflict_cnt", 64'(perf_conflict_cnt), 64'(m_perf));
`endif
        for (int i = 0; i < NF; i++) begin
            if (hold_mask[i])
                assert (req_valid[i] && rd_a[i] == hold_rd[i] && dat_a[i] == hold_dat[i])
                else $error("requester %0d changed while stalled", i);
            hold_rd[i]  <= rd_a[i];
            hold_dat[i] <= dat_a[i];
        end
        hold_mask <= rst ? '0 : (req_valid & ~req_ready);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [NF-1:0] done;
    logic          prev_rst;
    int            grants [NF];
    int            wait_c [NF];
    int            max_wait;
    logic [31:0]   perf0;

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        req_valid = 4'b1111;
        rd_a[0] = 6'd2;  rd_a[1] = 6'd5;  rd_a[2] = 6'd4;  rd_a[3] = 6'd7;
        for (int i = 0; i < NF; i++) dat_a[i] = 32'h1000 + 32'(i);
        perf0 = '0;

        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_wb_valid", 64'(wb_valid), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("release_ready", 64'(req_ready), 64'b0011);

        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("first_grant_wb_valid", 64'(wb_valid), 64'b11);
        chk("rst_again_ready", 64'(req_ready), 64'h0);

        next_cycle();
        rst = 1'b0;
        req_valid = 4'b1011;
        @(negedge clk);
        chk("mid_rst_discard", 64'(wb_valid), 64'b00);
        chk("rotate_ready0", 64'(req_ready), 64'b0011);

        next_cycle();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("rotate_wb_valid0", 64'(wb_valid), 64'b11);
        chk("rotate_port0_rd", 64'(wb_phys_rd[0 +: PRW]), 64'd2);
        chk("rotate_port1_rd", 64'(wb_phys_rd[PRW +: PRW]), 64'd5);
        chk("rotate_ready1", 64'(req_ready), 64'b1000);

        next_cycle();
        req_valid = 4'b0100;
        @(negedge clk);
        chk("rotate_wb_valid1", 64'(wb_valid), 64'b01);
        chk("rotate_fu3_rd", 64'(wb_phys_rd[0 +: PRW]), 64'd7);
        chk("ptr0_ready", 64'(req_ready), 64'b0100);

        next_cycle();
        req_valid = 4'b1001;
        @(negedge clk);
        chk("wrap_ready", 64'(req_ready), 64'b1001);

        next_cycle();
        req_valid = 4'b1111;
        flush = 1'b1;
        @(negedge clk);
        chk("wrap_port0_rd", 64'(wb_phys_rd[0 +: PRW]), 64'd7);
        chk("wrap_port1_rd", 64'(wb_phys_rd[PRW +: PRW]), 64'd2);
        chk("flush_ready", 64'(req_ready), 64'h0);

        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_wb_valid", 64'(wb_valid), 64'b00);
        chk("post_flush_ready", 64'(req_ready), 64'b0110);

        // Fairness soak: everyone valid for 20 cycles.
        for (int i = 0; i < NF; i++) begin
            grants[i] = 0;
            wait_c[i] = 0;
        end
        max_wait = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
`ifdef WB_ARB_PERF_EN
            if (c == 0) perf0 = perf_conflict_cnt;
`endif
            done = req_valid & req_ready;
            for (int i = 0; i < NF; i++) begin
                if (done[i]) begin
                    grants[i]++;
                    wait_c[i] = 0;
                end else begin
                    wait_c[i]++;
                    if (wait_c[i] > max_wait) max_wait = wait_c[i];
                end
            end
            next_cycle();
            for (int i = 0; i < NF; i++) if (done[i]) dat_a[i] = $urandom;
        end
        @(negedge clk);
        for (int i = 0; i < NF; i++) chk($sformatf("soak_grants_fu%0d", i), 64'(grants[i]), 64'd10);
        chk("soak_max_wait_ok", 64'(max_wait <= 1), 64'd1);
`ifdef WB_ARB_PERF_EN
        chk("soak_perf_delta", 64'(perf_conflict_cnt - perf0), 64'd20);
`endif

        // Randomized run honouring the stall contract.
        prev_rst = rst;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            done = req_valid & req_ready;
            prev_rst = rst;
            next_cycle();
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < NF; i++) begin
                if (!req_valid[i] || done[i] || prev_rst) begin
                    req_valid[i] = ($urandom_range(0, 99) < 65);
                    rd_a[i]      = PRW'($urandom);
                    dat_a[i]     = $urandom;
                end
            end
        end
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
